store_merge_unit: RTL and testbench

Data-memory write-side unit for the MIPS pipeline's MEM stage. Accepts `sw`/`sh`/`sb` store requests (byte address, R[rt] data, width mode) and writes a word-only synchronous data RAM. Word stores take one write cycle. Byte and halfword stores take two cycles: read the word, merge the lanes, write it back. This is the store-side counterpart of the load-side sign/zero extender; the pipeline stalls on `req_ready`.

---
 rtl/store_merge_unit_pkg.sv | 28 ++
 rtl/store_merge_unit_lane_merge.sv | 30 +++
 rtl/store_merge_unit.sv | 119 +++++++++++
 tb/tb_store_merge_unit.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/store_merge_unit_pkg.sv
// Shared declarations for the MEM-stage store path: store width encodings,
// store-merge FSM state encodings and the alignment rule.
package store_merge_unit_pkg;

    localparam logic [1:0] MEM_op_word = 2'b00;
    localparam logic [1:0] MEM_op_half = 2'b01;
    localparam logic [1:0] MEM_op_byte = 2'b10;

    typedef enum logic [1:0] {
        SMU_S_IDLE  = 2'b00,
        SMU_S_WRITE = 2'b01,
        SMU_S_READ  = 2'b10,
        SMU_S_MERGE = 2'b11
    } smu_state_e;

    // Mode 2'b11 is not a store width, so it is rejected like a misaligned access.
    function automatic logic smu_misaligned(input logic [1:0] mode, input logic [1:0] lane);
        logic bad;
        case (mode)
            MEM_op_word: bad = (lane != 2'b00);
            MEM_op_half: bad = lane[0];
            MEM_op_byte: bad = 1'b0;
            default:     bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/store_merge_unit_lane_merge.sv
// Little-endian lane insertion of store data into an existing memory word.
// Purely combinational; also intended for store-to-load forwarding.
module store_lane_merge
    import store_merge_unit_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] data,
    input  logic [1:0]  lane,
    input  logic [1:0]  mode,
    output logic [31:0] merged
);

    // Replace the addressed byte/half lanes; an illegal mode leaves the word intact.
    always_comb begin
        merged = old_word;
        case (mode)
            MEM_op_byte: merged[{lane, 3'b000} +: 8] = data[7:0];
            MEM_op_half: begin
                if (lane[1]) begin
                    merged[31:16] = data[15:0];
                end else begin
                    merged[15:0] = data[15:0];
                end
            end
            MEM_op_word: merged = data;
            default:     merged = old_word;
        endcase
    end

endmodule

// File: rtl/store_merge_unit.sv
// MEM-stage store unit: full-word stores write directly, byte/half stores do a
// read-merge-write on the word-only synchronous data RAM.
module store_merge_unit
    import store_merge_unit_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_data,
    input  logic [1:0]        req_mode,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [31:0]       mem_rdata,
    output logic              mem_wr_en,
    output logic [31:0]       mem_wdata,
    output logic              misalign
);

    smu_state_e        state_r;
    smu_state_e        next_state_s;
    logic [ADDR_W+1:0] addr_r;
    logic [31:0]       data_r;
    logic [1:0]        mode_r;
    logic              misalign_r;
    logic              accept_s;
    logic              bad_s;
    logic [31:0]       merged_s;

    assign req_ready = (state_r == SMU_S_IDLE) && !rst;
    assign accept_s  = req_valid && req_ready;
    assign bad_s     = smu_misaligned(req_mode, req_addr[1:0]);
    assign misalign  = misalign_r;

    store_lane_merge u_lane_merge (
        .old_word (mem_rdata),
        .data     (data_r),
        .lane     (addr_r[1:0]),
        .mode     (mode_r),
        .merged   (merged_s)
    );

    // State register, request latch and one-cycle reject pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= SMU_S_IDLE;
            addr_r     <= '0;
            data_r     <= 32'h0000_0000;
            mode_r     <= 2'b00;
            misalign_r <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            misalign_r <= accept_s && bad_s;
            if (accept_s && !bad_s) begin
                addr_r <= req_addr[ADDR_W+1:0];
                data_r <= req_data;
                mode_r <= req_mode;
            end else begin
                addr_r <= addr_r;
                data_r <= data_r;
                mode_r <= mode_r;
            end
        end
    end

    // Next-state selection: rejected requests never leave IDLE.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            SMU_S_IDLE: begin
                if (accept_s && !bad_s) begin
                    if (req_mode == MEM_op_word) begin
                        next_state_s = SMU_S_WRITE;
                    end else begin
                        next_state_s = SMU_S_READ;
                    end
                end else begin
                    next_state_s = SMU_S_IDLE;
                end
            end
            SMU_S_WRITE: next_state_s = SMU_S_IDLE;
            SMU_S_READ:  next_state_s = SMU_S_MERGE;
            SMU_S_MERGE: next_state_s = SMU_S_IDLE;
            default:     next_state_s = SMU_S_IDLE;
        endcase
    end

    // RAM-side outputs decoded from state; MERGE writes the word returned by the READ.
    always_comb begin
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
        mem_wdata = 32'h0000_0000;
        mem_addr  = '0;
        case (state_r)
            SMU_S_WRITE: begin
                mem_wr_en = 1'b1;
                mem_wdata = data_r;
                mem_addr  = addr_r[ADDR_W+1:2];
            end
            SMU_S_READ: begin
                mem_rd_en = 1'b1;
                mem_addr  = addr_r[ADDR_W+1:2];
            end
            SMU_S_MERGE: begin
                mem_wr_en = 1'b1;
                mem_wdata = merged_s;
                mem_addr  = addr_r[ADDR_W+1:2];
            end
            default: begin
                mem_rd_en = 1'b0;
                mem_wr_en = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_store_merge_unit.sv
// Directed self-checking bench for store_merge_unit with a behavioural
// synchronous word RAM attached to the memory port.
module tb_store_merge_unit;

    localparam int ADDR_W = 10;
    localparam logic [1:0] M_WORD = 2'b00;
    localparam logic [1:0] M_HALF = 2'b01;
    localparam logic [1:0] M_BYTE = 2'b10;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [31:0]       req_addr;
    logic [31:0]       req_data;
    logic [1:0]        req_mode;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic [31:0]       mem_rdata;
    logic              mem_wr_en;
    logic [31:0]       mem_wdata;
    logic              misalign;

    logic [31:0] ram [0:(1<<ADDR_W)-1];
    int          wr_log[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    store_merge_unit #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_mode  (req_mode),
        .mem_addr  (mem_addr),
        .mem_rd_en (mem_rd_en),
        .mem_rdata (mem_rdata),
        .mem_wr_en (mem_wr_en),
        .mem_wdata (mem_wdata),
        .misalign  (misalign)
    );

    always #5 clk = ~clk;

    // Synchronous word RAM, read data one cycle after the strobe.
    always @(posedge clk) begin
        if (mem_wr_en) begin
            ram[mem_addr] <= mem_wdata;
            wr_log.push_back(int'(mem_addr));
        end
        if (mem_rd_en) mem_rdata <= ram[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [1:0] m);
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        req_mode  = m;
    endtask

    task automatic partial_store(input string tag, input logic [31:0] a, input logic [31:0] d,
                                 input logic [1:0] m, input logic [31:0] exp_word);
        drive(a, d, m);
        tick();
        req_valid = 1'b0;
        req_data  = 32'hFFFF_FFFF;
        check({tag, " rd_en"}, {31'd0, mem_rd_en}, 32'd1);
        check({tag, " rd addr"}, {22'd0, mem_addr}, a >> 2);
        check({tag, " rd wr_en"}, {31'd0, mem_wr_en}, 32'd0);
        tick();
        check({tag, " wr_en"}, {31'd0, mem_wr_en}, 32'd1);
        check({tag, " wdata"}, mem_wdata, exp_word);
        check({tag, " wr addr"}, {22'd0, mem_addr}, a >> 2);
        check({tag, " wr rd_en"}, {31'd0, mem_rd_en}, 32'd0);
        tick();
        check({tag, " ready"}, {31'd0, req_ready}, 32'd1);
        check({tag, " ram"}, ram[a >> 2], exp_word);
    endtask

    task automatic reject(input string tag, input logic [31:0] a, input logic [1:0] m);
        drive(a, 32'h1234_5678, m);
        tick();
        req_valid = 1'b0;
        check({tag, " misalign"}, {31'd0, misalign}, 32'd1);
        check({tag, " ready"}, {31'd0, req_ready}, 32'd1);
        check({tag, " strobes"}, {30'd0, mem_rd_en, mem_wr_en}, 32'd0);
        tick();
        check({tag, " pulse end"}, {31'd0, misalign}, 32'd0);
        check({tag, " strobes2"}, {30'd0, mem_rd_en, mem_wr_en}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] seq_addr [3];
        logic [31:0] seq_data [3];
        logic [1:0]  seq_mode [3];
        int          acc_cyc  [3];
        int          idx;
        int          nlog;
        logic        acc;

        for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = 32'h0000_0000;
        mem_rdata = 32'h0000_0000;
        rst = 1'b1;
        req_valid = 1'b0;
        req_addr = 32'h0;
        req_data = 32'h0;
        req_mode = M_WORD;
        tick();
        tick();
        check("reset ready", {31'd0, req_ready}, 32'd0);
        check("reset outputs", {28'd0, mem_rd_en, mem_wr_en, misalign, |mem_addr}, 32'd0);
        check("reset wdata", mem_wdata, 32'd0);
        rst = 1'b0;
        #1;
        check("ready after reset", {31'd0, req_ready}, 32'd1);

        // Word store.
        drive(32'h0000_0010, 32'hDEAD_BEEF, M_WORD);
        tick();
        req_valid = 1'b0;
        check("word wr_en", {31'd0, mem_wr_en}, 32'd1);
        check("word addr", {22'd0, mem_addr}, 32'd4);
        check("word wdata", mem_wdata, 32'hDEAD_BEEF);
        check("word rd_en", {31'd0, mem_rd_en}, 32'd0);
        check("word busy", {31'd0, req_ready}, 32'd0);
        tick();
        check("word ready", {31'd0, req_ready}, 32'd1);
        check("word wr done", {31'd0, mem_wr_en}, 32'd0);
        check("word idle addr", {22'd0, mem_addr}, 32'd0);
        check("word ram", ram[4], 32'hDEAD_BEEF);

        ram[1] = 32'h1122_3344;
        partial_store("byte6", 32'h0000_0006, 32'h0000_00AA, M_BYTE, 32'h11AA_3344);
        ram[2] = 32'h1122_3344;
        partial_store("halfA", 32'h0000_000A, 32'h1234_BEEF, M_HALF, 32'hBEEF_3344);
        ram[2] = 32'h1122_3344;
        partial_store("half8", 32'h0000_0008, 32'h1234_BEEF, M_HALF, 32'h1122_BEEF);
        ram[5] = 32'hA0B0_C0D0;
        partial_store("byte17", 32'h0000_0017, 32'h0000_0099, M_BYTE, 32'h99B0_C0D0);

        nlog = wr_log.size();
        reject("half3", 32'h0000_0003, M_HALF);
        reject("word2", 32'h0000_0002, M_WORD);
        reject("mode3", 32'h0000_0000, 2'b11);
        check("reject no writes", wr_log.size(), nlog);

        // Back-to-back with req_valid held; garbage data while not ready.
        seq_addr = '{32'h0000_0020, 32'h0000_0021, 32'h0000_0024};
        seq_data = '{32'hCAFE_F00D, 32'h0000_0055, 32'h0102_0304};
        seq_mode = '{M_WORD, M_BYTE, M_WORD};
        ram[8] = 32'h0;
        ram[9] = 32'h0;
        wr_log.delete();
        idx = 0;
        for (int c = 0; c < 20 && idx < 3; c++) begin
            req_valid = 1'b1;
            req_addr  = req_ready ? seq_addr[idx] : 32'h0000_0030;
            req_data  = req_ready ? seq_data[idx] : 32'h5A5A_5A5A;
            req_mode  = req_ready ? seq_mode[idx] : M_HALF;
            acc = req_ready;
            tick();
            if (acc) begin
                acc_cyc[idx] = c;
                idx++;
            end
        end
        req_valid = 1'b0;
        check("b2b all accepted", idx, 3);
        tick();
        tick();
        tick();
        if (idx == 3) begin
            check("b2b accept gap1", acc_cyc[1] - acc_cyc[0], 2);
            check("b2b accept gap2", acc_cyc[2] - acc_cyc[1], 3);
        end
        check("b2b write count", wr_log.size(), 3);
        if (wr_log.size() == 3) begin
            check("b2b order0", wr_log[0], 8);
            check("b2b order1", wr_log[1], 8);
            check("b2b order2", wr_log[2], 9);
        end
        check("b2b ram8", ram[8], 32'hCAFE_550D);
        check("b2b ram9", ram[9], 32'h0102_0304);

        // Reset during the READ cycle of a byte store.
        ram[3] = 32'h5566_7788;
        nlog = wr_log.size();
        drive(32'h0000_000C, 32'h0000_00EE, M_BYTE);
        tick();
        req_valid = 1'b0;
        check("rst rd_en", {31'd0, mem_rd_en}, 32'd1);
        rst = 1'b1;
        tick();
        check("rst outputs", {28'd0, mem_rd_en, mem_wr_en, misalign, |mem_addr}, 32'd0);
        check("rst wdata", mem_wdata, 32'd0);
        check("rst ready low", {31'd0, req_ready}, 32'd0);
        rst = 1'b0;
        #1;
        check("rst ready back", {31'd0, req_ready}, 32'd1);
        tick();
        check("rst no wr", {31'd0, mem_wr_en}, 32'd0);
        tick();
        check("rst ram", ram[3], 32'h5566_7788);
        check("rst no writes", wr_log.size(), nlog);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
